ti_share_masker: RTL

- Produces shares for the threshold-implementation S-box datapath; it is the masking (producer) end of the share interface that the TI component functions consume.
- Accepts one unshared byte per handshake.
- Splits the byte into SHARES Boolean shares using fresh randomness from an internal LFSR.
- Presents the packed shares on a registered valid/ready output.
- Owns LFSR seeding and warm-up so that no share leaves before the generator is conditioned.

---
 rtl/ti_pkg.sv | 29 ++
 rtl/ti_lfsr.sv | 33 +++
 rtl/ti_share_masker.sv | 113 +++++++++++
 3 files changed

// File: rtl/ti_pkg.sv
// Shared definitions for the threshold-implementation share producer:
// LFSR constants, tap positions, FSM state type and the unrolled LFSR step.
package ti_pkg;

   localparam int          LFSR_W       = 32;
   localparam logic [31:0] LFSR_DEFAULT = 32'hACE1_2468;
   localparam int          TAP_A        = 31;
   localparam int          TAP_B        = 21;
   localparam int          TAP_C        = 1;
   localparam int          TAP_D        = 0;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      WARMUP   = 2'd1,
      RUN      = 2'd2
   } state_t;

   // nsteps must be an elaboration-time constant so the loop unrolls
   function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s,
                                                      input int nsteps);
      logic [LFSR_W-1:0] t;
      t = s;
      for (int i = 0; i < nsteps; i++) begin
         t = {t[LFSR_W-2:0], t[TAP_A] ^ t[TAP_B] ^ t[TAP_C] ^ t[TAP_D]};
      end
      return t;
   endfunction

endpackage

// File: rtl/ti_lfsr.sv
// 32-bit Fibonacci LFSR for mask generation; r is the low RAND_W bits of the
// state one advance ahead, i.e. what the register holds after the next advance.
module ti_lfsr
   import ti_pkg::*;
#(
   parameter int RAND_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [RAND_W-1:0] r
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_adv;

   assign lfsr_adv = lfsr_advance(lfsr_q, RAND_W);
   assign r        = lfsr_adv[RAND_W-1:0];

   // An all-zero seed would lock the LFSR, so it is replaced by the default
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_DEFAULT;
      end else if (load) begin
         lfsr_q <= (seed == '0) ? LFSR_DEFAULT : seed;
      end else if (advance) begin
         lfsr_q <= lfsr_adv;
      end
   end

endmodule

// File: rtl/ti_share_masker.sv
// Boolean masking front end for the TI S-box: splits each accepted byte into
// SHARES shares. Optional zero_rand port under macro TI_MASK_ZERO_RAND_EN.
module ti_share_masker
   import ti_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SHARES     = 3,
   parameter int WARMUP_CYC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef TI_MASK_ZERO_RAND_EN
   input  logic                    zero_rand,
`endif
   input  logic [31:0]             seed,
   input  logic                    seed_load,
   input  logic [WIDTH-1:0]        in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [SHARES*WIDTH-1:0] out_shares,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    seeded
);

   localparam int RAND_W = (SHARES - 1) * WIDTH;
   localparam int CNT_W  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYC - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        warm_cnt;
   logic                    accept;
   logic                    lfsr_adv_en;
   logic [RAND_W-1:0]       r;
   logic [RAND_W-1:0]       r_eff;
   logic [SHARES*WIDTH-1:0] shares_p0;
   logic [SHARES*WIDTH-1:0] shares_p1;
   logic                    vld_p1;

   ti_lfsr #(.RAND_W(RAND_W)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (seed_load),
      .seed    (seed),
      .advance (lfsr_adv_en),
      .r       (r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= UNSEEDED;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (seed_load) begin
         state_d = WARMUP;
      end else begin
         case (state_q)
            UNSEEDED: state_d = UNSEEDED;
            WARMUP:   if (warm_cnt == WARM_LAST) state_d = RUN;
            RUN:      state_d = RUN;
            default:  state_d = UNSEEDED;
         endcase
      end
   end

   // A reseed takes priority over any transfer attempted in the same cycle
   always_comb begin
      seeded      = (state_q == RUN);
      in_ready    = (state_q == RUN) && (!vld_p1 || out_ready) && !seed_load;
      lfsr_adv_en = (state_q == WARMUP) || (in_valid && in_ready);
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 warm_cnt <= '0;
      else if (seed_load)         warm_cnt <= '0;
      else if (state_q == WARMUP) warm_cnt <= warm_cnt + 1'b1;
   end

   // ---- stage p0: mask the input with the freshly advanced random word ----
   always_comb begin
      r_eff = r;
`ifdef TI_MASK_ZERO_RAND_EN
      if (zero_rand) r_eff = '0;
`endif
      shares_p0              = '0;
      shares_p0[WIDTH-1:0]   = in_data;
      for (int k = 1; k < SHARES; k++) begin
         shares_p0[k*WIDTH +: WIDTH] = r_eff[(k-1)*WIDTH +: WIDTH];
         shares_p0[WIDTH-1:0]        = shares_p0[WIDTH-1:0] ^ r_eff[(k-1)*WIDTH +: WIDTH];
      end
   end

   // ---- stage p1: registered output, held while downstream stalls ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         shares_p1 <= '0;
      end else if (accept) begin
         vld_p1    <= 1'b1;
         shares_p1 <= shares_p0;
      end else if (out_ready) begin
         vld_p1    <= 1'b0;
      end
   end

   assign out_valid  = vld_p1;
   assign out_shares = shares_p1;

endmodule
